// File: rtl/dealer_pkg.sv
// Shared types and constants for the card dealer arbiter: FSM states,
// the legal card value range and the retry counter width.
package dealer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } dealer_state_t;

    localparam int CARD_MIN = 1;
    localparam int CARD_MAX = 10;

    localparam int                 RETRY_W   = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping modulo NUM_REQ. any is low when no request is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        int cand;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/card_dealer_arbiter.sv
// Shares one random card generator among NUM_REQ players: round-robin grant,
// generator handshake with timeout/invalid-value retry, one-cycle delivery strobe.
module card_dealer_arbiter
    import dealer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int VALUE_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  card_valid,
    output logic [VALUE_W-1:0]  card_value,
    output logic                busy,
    output logic                gen_request,
    input  logic                gen_ready,
    input  logic [VALUE_W-1:0]  gen_value,
    output logic [RETRY_W-1:0]  retry_cnt,
    output dealer_state_t       dbg_state
);

    // Handshakes: req is a level held until its card_valid strobe; gen_request
    // is a one-cycle pulse, and gen_ready is a one-cycle pulse honoured only in
    // WAIT, with gen_value qualified by it in the same cycle.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = 8;

    dealer_state_t      state, state_nxt;
    logic [IDX_W-1:0]   ptr, grant, arb_idx;
    logic               arb_any;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               value_ok, timed_out, reissue;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign value_ok  = (int'(gen_value) >= CARD_MIN) && (int'(gen_value) <= CARD_MAX);
    // WAIT is entered the cycle after gen_request with tmo_cnt = 0, so the reissue
    // lands exactly TIMEOUT cycles after the previous gen_request.
    assign timed_out = (int'(tmo_cnt) >= TIMEOUT - 2);
    assign reissue   = (state == WAIT) && (state_nxt == ISSUE);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (gen_ready)      state_nxt = value_ok ? DELIVER : ISSUE;
                else if (timed_out) state_nxt = ISSUE;
            end
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            tmo_cnt     <= '0;
            card_valid  <= '0;
            card_value  <= '0;
            gen_request <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            gen_request <= (state_nxt == ISSUE);
            card_valid  <= '0;
            card_value  <= '0;

            if (state == IDLE && arb_any) grant <= arb_idx;

            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;

            // The card goes to grant even if its requester has since dropped req.
            if (state == WAIT && state_nxt == DELIVER) begin
                card_valid <= NUM_REQ'(1) << grant;
                card_value <= gen_value;
            end

            if (state == DELIVER)
                ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

            if (reissue && retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_card_dealer_arbiter.sv
// Bench for card_dealer_arbiter: reset checks, a vector table of single-card
// transactions, hand-written corner sequences and randomized transactions.
module tb_card_dealer_arbiter;
    import dealer_pkg::*;

    localparam int NR      = 4;
    localparam int VW      = 4;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] card_valid;
    logic [VW-1:0] card_value;
    logic          busy;
    logic          gen_request;
    logic          gen_ready;
    logic [VW-1:0] gen_value;
    logic [7:0]    retry_cnt;
    dealer_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_retry = 0;
    int mptr = 0;

    card_dealer_arbiter #(
        .NUM_REQ (NR),
        .VALUE_W (VW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .card_valid  (card_valid),
        .card_value  (card_value),
        .busy        (busy),
        .gen_request (gen_request),
        .gen_ready   (gen_ready),
        .gen_value   (gen_value),
        .retry_cnt   (retry_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] rq;
        int            gap;
        int            dly;
        logic [VW-1:0] v;
        logic [NR-1:0] exp_cv;
        int            exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_gen_req(output int n);
        n = 0;
        while (!gen_request && n < 40) begin
            tick();
            n++;
        end
        chk("gen_request_seen", 32'(gen_request), 32'd1);
    endtask

    function automatic int pick(input logic [NR-1:0] p, input int start);
        for (int k = 0; k < NR; k++)
            if (p[(start + k) % NR]) return (start + k) % NR;
        return 0;
    endfunction

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // One card: nto silent timeouts, then ninv invalid answers, then value v.
    task automatic do_card(input logic [NR-1:0] rq, input int gap, input int nto,
                           input int ninv, input int dly, input logic [VW-1:0] v,
                           input logic [VW-1:0] bad_a, input logic [VW-1:0] bad_b,
                           input logic [NR-1:0] exp_cv, input int exp_lat);
        int t0, n;
        if (gap > 0) begin
            req = '0;
            repeat (gap) tick();
        end
        req = rq;
        t0  = cyc;
        wait_gen_req(n);
        for (int i = 0; i < nto; i++) begin
            tick();
            wait_gen_req(n);
            chk("timeout_spacing", 32'(n + 1), 32'(TIMEOUT));
        end
        for (int i = 0; i < ninv; i++) begin
            repeat (dly) tick();
            gen_ready = 1'b1;
            gen_value = (i == 0) ? bad_a : bad_b;
            tick();
            gen_ready = 1'b0;
            chk("invalid_reissue", 32'(gen_request), 32'd1);
            chk("invalid_no_strobe", 32'(card_valid), 32'd0);
        end
        repeat (dly) tick();
        gen_ready = 1'b1;
        gen_value = v;
        tick();
        gen_ready = 1'b0;
        exp_retry = sat(exp_retry + nto + ninv);
        chk("card_valid", 32'(card_valid), 32'(exp_cv));
        chk("card_value", 32'(card_value), 32'(v));
        chk("retry_cnt", 32'(retry_cnt), 32'(exp_retry));
        chk("latency", 32'(cyc - t0), 32'(exp_lat));
    endtask

    initial begin
        int n;
        logic [NR-1:0] pending;

        rst = 1'b1; req = '0; gen_ready = 1'b0; gen_value = '0;
        repeat (3) tick();
        chk("rst_card_valid", 32'(card_valid), 32'd0);
        chk("rst_card_value", 32'(card_value), 32'd0);
        chk("rst_gen_request", 32'(gen_request), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Row 0 leaves ptr at 1, so the 1111 rotation starts at requester 1.
        vecs[0] = '{4'b0001, 2, 1, 4'd7,  4'b0001, 3};
        vecs[1] = '{4'b1111, 1, 1, 4'd3,  4'b0010, 3};
        vecs[2] = '{4'b1111, 0, 1, 4'd10, 4'b0100, 4};
        vecs[3] = '{4'b1111, 0, 1, 4'd1,  4'b1000, 4};
        vecs[4] = '{4'b1111, 0, 1, 4'd9,  4'b0001, 4};
        vecs[5] = '{4'b1111, 0, 1, 4'd2,  4'b0010, 4};
        vecs[6] = '{4'b1001, 1, 3, 4'd6,  4'b1000, 5};
        vecs[7] = '{4'b0110, 1, 2, 4'd4,  4'b0010, 4};
        for (int i = 0; i < 8; i++)
            do_card(vecs[i].rq, vecs[i].gap, 0, 0, vecs[i].dly, vecs[i].v,
                    '0, '0, vecs[i].exp_cv, vecs[i].exp_lat);

        // Timeout: generator silent 20 cycles after the first request, then 5.
        do_card(4'b0001, 1, 1, 0, 5, 4'd5, '0, '0, 4'b0001, 22);
        // Invalid values 0 and 12 before a legal 10.
        do_card(4'b0001, 1, 0, 2, 1, 4'd10, 4'd0, 4'd12, 4'b0001, 7);

        // Withdrawn request: 0100 drops in WAIT, card still delivered; 0010 next.
        req = '0;
        tick();
        req = 4'b0100;
        wait_gen_req(n);
        req = 4'b0010;
        tick();
        gen_ready = 1'b1;
        gen_value = 4'd8;
        tick();
        gen_ready = 1'b0;
        chk("withdrawn_valid", 32'(card_valid), 32'b0100);
        chk("withdrawn_value", 32'(card_value), 32'd8);
        do_card(4'b0010, 0, 0, 0, 1, 4'd4, '0, '0, 4'b0010, 4);

        // Reset mid-WAIT with a late gen_ready after release.
        req = '0;
        tick();
        req = 4'b1000;
        wait_gen_req(n);
        tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        tick();
        gen_ready = 1'b1;
        gen_value = 4'd3;
        tick();
        gen_ready = 1'b0;
        chk("post_rst_card_valid", 32'(card_valid), 32'd0);
        chk("post_rst_card_value", 32'(card_value), 32'd0);
        chk("post_rst_gen_request", 32'(gen_request), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_retry", 32'(retry_cnt), 32'd0);
        chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        tick();
        chk("post_rst_no_strobe", 32'(card_valid), 32'd0);
        chk("post_rst_idle", 32'(dbg_state), 32'(IDLE));
        exp_retry = 0;
        mptr = 0;

        // Randomized transactions: players keep requests pending until served.
        pending = '0;
        for (int t = 0; t < 40; t++) begin
            int w, nto, ninv, dly, gap, lat;
            logic [VW-1:0] bad_a, bad_b, v;
            pending = pending | NR'($urandom_range(0, 15));
            if (pending == '0) pending[$urandom_range(0, NR - 1)] = 1'b1;
            gap   = (t == 0) ? 1 : 0;
            nto   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            ninv  = $urandom_range(0, 2);
            dly   = $urandom_range(1, 13);
            v     = VW'($urandom_range(CARD_MIN, CARD_MAX));
            bad_a = ($urandom_range(0, 1) == 0) ? VW'(0) : VW'($urandom_range(11, 15));
            bad_b = ($urandom_range(0, 1) == 0) ? VW'(0) : VW'($urandom_range(11, 15));
            w     = pick(pending, mptr);
            lat   = ((gap == 0) ? 2 : 1) + TIMEOUT * nto + ninv * (dly + 1) + dly + 1;
            do_card(pending, gap, nto, ninv, dly, v, bad_a, bad_b, NR'(1) << w, lat);
            mptr = (w + 1) % NR;
            if ($urandom_range(0, 3) != 0) pending[w] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
